// File: rtl/cpu_pkg.sv
// Shared datapath defaults for the CPU select/encode path, plus the index-width helper.
package cpu_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int RA_LSB_DEF   = 23;
  localparam int RB_LSB_DEF   = 19;
  localparam int RC_LSB_DEF   = 15;
  localparam int IMM_W_DEF    = 19;

  // Width of a register index; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_REGS_DEF);

  typedef logic [IDX_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_pending_scoreboard.sv
// One pending-write bit per register. A set wins over a clear to the same index,
// and a query can be bypassed by a write retiring in the same cycle.
module reg_pending_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             set_en_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] query_idx_i,
  input  logic             bypass_i,
  output logic             is_pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_hit, clr_hit, query_hit;

  // Indices at or above NUM_REGS match no bit, so they are silently ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign set_hit[gi]   = set_en_i && (set_idx_i == IDX_W'(gi));
      assign clr_hit[gi]   = clr_en_i && (clr_idx_i == IDX_W'(gi));
      assign query_hit[gi] = (query_idx_i == IDX_W'(gi));
      assign pending_d[gi] = set_hit[gi] | (pending_q[gi] & ~clr_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign is_pending_o = (|(pending_q & query_hit)) & ~bypass_i;

endmodule

// File: rtl/reg_select_encode_unit.sv
// Registered-IR register select/encode: one-hot regfile enables, sign-extended
// C constant, and a stall when a read hits a register with a pending write.
module reg_select_encode_unit
  import cpu_pkg::*;
#(
  parameter int  NUM_REGS = NUM_REGS_DEF,
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  RA_LSB   = RA_LSB_DEF,
  parameter int  RB_LSB   = RB_LSB_DEF,
  parameter int  RC_LSB   = RC_LSB_DEF,
  parameter int  IMM_W    = IMM_W_DEF,
  localparam int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_load,
  input  logic [DATA_W-1:0]   IR_in,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                wr_issue,
  input  logic                wr_done,
  input  logic [IDX_W-1:0]    wr_done_idx,
  output logic [NUM_REGS-1:0] RXin,
  output logic [NUM_REGS-1:0] RXout,
  output logic                BAzero,
  output logic [DATA_W-1:0]   CSignExtended,
  output logic                stall,
  output logic                sel_invalid
);

  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [IDX_W-1:0]    sel_q, sel_d, sel;
  logic [IDX_W-1:0]    ra_idx, rb_idx, rc_idx;
  logic [NUM_REGS-1:0] sel_oh;
  logic                rd_en, ba_r0, bypass, sel_pending;
  logic                unused_ir;

  assign ra_idx = ir_q[RA_LSB +: IDX_W];
  assign rb_idx = ir_q[RB_LSB +: IDX_W];
  assign rc_idx = ir_q[RC_LSB +: IDX_W];

  // With no strobe the previous selection is held so multi-step reads stay put.
  always_comb begin
    sel = sel_q;
    if (Gra)      sel = ra_idx;
    else if (Grb) sel = rb_idx;
    else if (Grc) sel = rc_idx;
    sel_d = sel;
    ir_d  = ir_load ? IR_in : ir_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ir_q  <= '0;
      sel_q <= '0;
    end else begin
      ir_q  <= ir_d;
      sel_q <= sel_d;
    end
  end

  // An out-of-range selection decodes to no bit at all.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_oh
      assign sel_oh[gi] = (sel == IDX_W'(gi));
    end
  endgenerate

  assign rd_en       = Rout | BAout;
  assign ba_r0       = BAout && (sel == '0);
  assign sel_invalid = (32'(sel) >= NUM_REGS);
  assign BAzero      = ba_r0;
  assign RXout       = (rd_en && !ba_r0) ? sel_oh : '0;
  assign RXin        = (Rin && !rd_en) ? sel_oh : '0;

  assign CSignExtended = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  assign bypass = wr_done && (wr_done_idx == sel);

  reg_pending_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_scoreboard (
    .clk_i        (clock),
    .srst_i       (clear),
    .set_en_i     (wr_issue),
    .set_idx_i    (ra_idx),
    .clr_en_i     (wr_done),
    .clr_idx_i    (wr_done_idx),
    .query_idx_i  (sel),
    .bypass_i     (bypass),
    .is_pending_o (sel_pending)
  );

  // Stall is advisory; the enables stay live and the control unit holds its step.
  assign stall = rd_en & sel_pending;

  assign unused_ir = ^ir_q;

endmodule
